// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix instruction-fetch front end.
package mat_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_DRAIN,
    FETCH_HALTED
  } MatFetchState_t;

  localparam logic [7:0] MAT_HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/mat_fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instruction}, with single-cycle flush.
module mat_fetch_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 160,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head_entry,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Entry storage; no reset needed because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_q[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem_q[rd_ptr];
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/mat_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, halt detection, branch redirect
// and a prefetch queue feeding the decoder over valid/ready.
//
// state        | meaning
// FETCH_IDLE   | out of reset, waiting for start
// FETCH_RUN    | fetching one word per cycle while the queue has room
// FETCH_DRAIN  | halt word seen, no fetch, waiting for decoder to empty queue
// FETCH_HALTED | program finished, done high, start relaunches
module mat_fetch_unit
  import mat_pkg::*;
#(
  parameter int INST_MEM_ADDR_SIZE  = 32,
  parameter int INST_MEM_WIDTH_SIZE = 128,
  parameter int INST_MEM_SIZE       = 1024,
  parameter int DEPTH               = 4,
  parameter int OPCODE_SIZE         = 8,
  parameter logic [OPCODE_SIZE-1:0] HALT_OPCODE = OPCODE_SIZE'(MAT_HALT_OPCODE),
  localparam int CNT_W              = $clog2(DEPTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INST_MEM_ADDR_SIZE-1:0]  start_pc,
  output logic                           done,
  output logic [INST_MEM_ADDR_SIZE-1:0]  inst_mem_addr,
  input  logic [INST_MEM_WIDTH_SIZE-1:0] inst_mem_value,
  output logic                           inst_valid,
  input  logic                           inst_ready,
  output logic [INST_MEM_WIDTH_SIZE-1:0] inst_data,
  output logic [INST_MEM_ADDR_SIZE-1:0]  inst_pc,
  input  logic                           redirect_valid,
  input  logic [INST_MEM_ADDR_SIZE-1:0]  redirect_pc,
  output logic [CNT_W-1:0]               queue_count
);

  localparam int ENTRY_W = INST_MEM_ADDR_SIZE + INST_MEM_WIDTH_SIZE;
  localparam logic [INST_MEM_ADDR_SIZE-1:0] MEM_SIZE_C = INST_MEM_ADDR_SIZE'(INST_MEM_SIZE);

  MatFetchState_t                state_q, state_nxt;
  logic [INST_MEM_ADDR_SIZE-1:0] pc_q, pc_nxt, pc_inc;
  logic                          push, pop, flush, full, empty, is_halt, emptying;
  logic [ENTRY_W-1:0]            head_entry;

  function automatic logic [INST_MEM_ADDR_SIZE-1:0] wrap_addr(
    input logic [INST_MEM_ADDR_SIZE-1:0] addr
  );
    return addr % MEM_SIZE_C;
  endfunction

  assign pc_inc   = (pc_q == MEM_SIZE_C - 1'b1) ? '0 : pc_q + 1'b1;
  assign is_halt  = (inst_mem_value[INST_MEM_WIDTH_SIZE-1 -: OPCODE_SIZE] == HALT_OPCODE);
  assign pop      = inst_valid && inst_ready;
  // Queue will be empty after this edge, so the drain phase can be skipped.
  assign emptying = empty || (queue_count == CNT_W'(1) && pop);

  // State and PC registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
    end
  end

  // Next-state, PC update and queue control.
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      FETCH_IDLE, FETCH_HALTED: begin
        if (start) begin
          pc_nxt    = wrap_addr(start_pc);
          state_nxt = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if (redirect_valid) begin
          flush     = 1'b1;
          pc_nxt    = wrap_addr(redirect_pc);
        end else if (!full || pop) begin
          if (is_halt) begin
            state_nxt = emptying ? FETCH_HALTED : FETCH_DRAIN;
          end else begin
            push   = 1'b1;
            pc_nxt = pc_inc;
          end
        end
      end
      FETCH_DRAIN: begin
        if (redirect_valid) begin
          flush     = 1'b1;
          pc_nxt    = wrap_addr(redirect_pc);
          state_nxt = FETCH_RUN;
        end else if (emptying) begin
          state_nxt = FETCH_HALTED;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  mat_fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry ({pc_q, inst_mem_value}),
    .pop        (pop),
    .flush      (flush),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .count      (queue_count)
  );

  assign inst_mem_addr = pc_q;
  assign inst_valid    = !empty;
  assign inst_pc       = head_entry[ENTRY_W-1 -: INST_MEM_ADDR_SIZE];
  assign inst_data     = head_entry[INST_MEM_WIDTH_SIZE-1:0];
  assign done          = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_mat_fetch_unit.sv
// Directed bench for mat_fetch_unit with a scoreboard of expected consumed PCs.
module tb_mat_fetch_unit;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  start_pc;
  logic         done;
  logic [31:0]  inst_mem_addr;
  logic [127:0] inst_mem_value;
  logic         inst_valid;
  logic         inst_ready;
  logic [127:0] inst_data;
  logic [31:0]  inst_pc;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [2:0]   queue_count;

  logic [127:0] mem [1024];
  logic [31:0]  sb_q [$];
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] HALT_W = {8'hFF, 120'd0};

  always #5 clock = ~clock;

  assign inst_mem_value = mem[inst_mem_addr[9:0]];

  mat_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .start_pc       (start_pc),
    .done           (done),
    .inst_mem_addr  (inst_mem_addr),
    .inst_mem_value (inst_mem_value),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .queue_count    (queue_count)
  );

  function automatic logic [127:0] mk_word(input int i);
    return {8'h01, 88'd0, 32'hA500_0000 ^ 32'(i)};
  endfunction

  task automatic fill(input int halt_addr);
    for (int i = 0; i < 1024; i++) mem[i] = mk_word(i);
    mem[halt_addr] = HALT_W;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Monitor: every accepted instruction must match the next expected PC and word.
  always @(negedge clock) begin
    if (!reset && inst_valid) begin
      if (inst_data[127:120] == 8'hFF) begin
        checks++;
        errors++;
        $display("FAIL halt_leak: halt word on inst_data at pc %0d", inst_pc);
      end
      if (inst_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc %0d expected none", inst_pc);
        end else begin
          logic [31:0] e_pc;
          e_pc = sb_q.pop_front();
          if (inst_pc !== e_pc || inst_data !== mk_word(int'(e_pc))) begin
            errors++;
            $display("FAIL sb_pop: got pc %0d data %h expected pc %0d data %h",
                     inst_pc, inst_data, e_pc, mk_word(int'(e_pc)));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = '0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    fill(5);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(queue_count), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_addr",  inst_mem_addr, 0);

    // 1: straight-line run 0..4 ending on halt at 5
    inst_ready = 1'b1; start_pc = 0;
    for (int i = 0; i < 5; i++) sb_q.push_back(32'(i));
    start = 1'b1; step(); start = 1'b0;
    chk("t1_valid_t1", 32'(inst_valid), 0);
    step();
    chk("t1_valid_t2", 32'(inst_valid), 1);
    chk("t1_pc_t2", inst_pc, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t1_done_t6", 32'(done), 0);
    step();
    chk("t1_done_t7", 32'(done), 1);
    chk("t1_valid_t7", 32'(inst_valid), 0);
    chk("t1_addr_halt", inst_mem_addr, 5);
    chk("t1_sb_empty", 32'(sb_q.size()), 0);

    // 2: back-pressure fills the queue, then steady push+pop
    fill(12);
    inst_ready = 1'b0; start_pc = 0;
    start = 1'b1; step(); start = 1'b0;
    chk("t2_count0", 32'(queue_count), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_fill", 32'(queue_count), 32'(k));
    end
    step();
    chk("t2_hold", 32'(queue_count), 4);
    chk("t2_addr", inst_mem_addr, 4);
    for (int i = 0; i < 12; i++) sb_q.push_back(32'(i));
    inst_ready = 1'b1;
    step();
    chk("t2_steady1", 32'(queue_count), 4);
    step();
    chk("t2_steady2", 32'(queue_count), 4);
    wait_done(60);
    chk("t2_sb_empty", 32'(sb_q.size()), 0);

    // 3: redirect flushes a full queue
    fill(44);
    inst_ready = 1'b0; start_pc = 10;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_count_full", 32'(queue_count), 4);
    chk("t3_head", inst_pc, 10);
    redirect_valid = 1'b1; redirect_pc = 40;
    step();
    redirect_valid = 1'b0;
    chk("t3_flush_count", 32'(queue_count), 0);
    chk("t3_flush_valid", 32'(inst_valid), 0);
    chk("t3_flush_addr", inst_mem_addr, 40);
    step();
    chk("t3_valid", 32'(inst_valid), 1);
    chk("t3_target", inst_pc, 40);
    for (int i = 40; i < 44; i++) sb_q.push_back(32'(i));
    inst_ready = 1'b1;
    wait_done(40);
    chk("t3_sb_empty", 32'(sb_q.size()), 0);
    chk("t3_addr_halt", inst_mem_addr, 44);

    // 4: PC wraps at the memory size
    fill(2);
    inst_ready = 1'b1; start_pc = 1022;
    sb_q.push_back(1022); sb_q.push_back(1023); sb_q.push_back(0); sb_q.push_back(1);
    start = 1'b1; step(); start = 1'b0;
    wait_done(40);
    chk("t4_sb_empty", 32'(sb_q.size()), 0);
    chk("t4_addr_halt", inst_mem_addr, 2);

    // 5: reset mid-run discards the queue
    fill(9);
    mem[103] = HALT_W;
    inst_ready = 1'b0; start_pc = 20;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t5_count3", 32'(queue_count), 3);
    reset = 1'b1;
    step();
    chk("t5_rst_count", 32'(queue_count), 0);
    chk("t5_rst_valid", 32'(inst_valid), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_addr", inst_mem_addr, 0);
    reset = 1'b0;
    start_pc = 7;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t5_valid", 32'(inst_valid), 1);
    chk("t5_first_pc", inst_pc, 7);

    // 6: redirect out of DRAIN (target reduced modulo size), then ignored in HALTED
    step(); step();
    chk("t6_drain_count", 32'(queue_count), 2);
    chk("t6_drain_done", 32'(done), 0);
    chk("t6_drain_addr", inst_mem_addr, 9);
    redirect_valid = 1'b1; redirect_pc = 1124;
    step();
    redirect_valid = 1'b0;
    chk("t6_redir_count", 32'(queue_count), 0);
    chk("t6_redir_addr", inst_mem_addr, 100);
    chk("t6_redir_done", 32'(done), 0);
    step();
    chk("t6_valid", 32'(inst_valid), 1);
    chk("t6_target", inst_pc, 100);
    for (int i = 100; i < 103; i++) sb_q.push_back(32'(i));
    inst_ready = 1'b1;
    wait_done(40);
    chk("t6_sb_empty", 32'(sb_q.size()), 0);
    redirect_valid = 1'b1; redirect_pc = 300;
    step();
    redirect_valid = 1'b0;
    chk("t6_halt_done", 32'(done), 1);
    chk("t6_halt_addr", inst_mem_addr, 103);
    step();
    chk("t6_halt_done2", 32'(done), 1);
    chk("t6_halt_valid", 32'(inst_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_fetch_unit.md
Name: mat_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the matrix control path. Replaces the single-instruction, fixed-width fetch inside the matrix controller.
- Streams instruction words from the combinational-read instruction memory into a DEPTH-entry prefetch queue.
- Hands instructions to the decoder over a valid/ready handshake.
- Supports start/halt sequencing and same-cycle branch redirect with queue flush.

Parameters:
- INST_MEM_ADDR_SIZE, 32, width of the word-indexed instruction address.
- INST_MEM_WIDTH_SIZE, 128, instruction word width in bits.
- INST_MEM_SIZE, 1024, number of instruction words; the PC wraps modulo this value.
- DEPTH, 4, prefetch queue entries; must be a power of two and at least 2.
- OPCODE_SIZE, 8, opcode field width, taken from the MSBs of the instruction word.
- HALT_OPCODE, 8'hFF, opcode value that terminates fetch.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  in IDLE or HALTED: begin fetching at start_pc.
- start_pc  in  INST_MEM_ADDR_SIZE  initial PC.
- done  out  1  high while HALTED.
- inst_mem_addr  out  INST_MEM_ADDR_SIZE  current fetch PC to the instruction memory.
- inst_mem_value  in  INST_MEM_WIDTH_SIZE  combinational read data for inst_mem_addr.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decoder accepts the head this cycle.
- inst_data  out  INST_MEM_WIDTH_SIZE  head instruction.
- inst_pc  out  INST_MEM_ADDR_SIZE  PC of the head instruction.
- redirect_valid  in  1  branch taken: flush the queue and refetch.
- redirect_pc  in  INST_MEM_ADDR_SIZE  redirect target.
- queue_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset:
  - state=IDLE; pc=0; queue_count=0; rd/wr pointers=0.
  - inst_valid=0, done=0, inst_mem_addr=0.
  - inst_data and inst_pc are don't-care while inst_valid=0.
  - Reset asserted mid-operation discards all queued entries and any pending halt.
- Outputs:
  - inst_mem_addr = pc (registered).
  - inst_valid = (queue_count != 0).
  - inst_data and inst_pc come from the head entry.
- IDLE: if start, load pc<=start_pc and go to RUN. No fetch occurs in the start cycle.
- RUN:
  - Push condition: queue_count<DEPTH, or queue full and pop happening in the same cycle.
  - On push: capture {pc, inst_mem_value}, then pc <= (pc+1) mod INST_MEM_SIZE.
  - If inst_mem_value[MSB -: OPCODE_SIZE]==HALT_OPCODE:
    - the halt word is NOT pushed;
    - pc holds at the halt address;
    - go to DRAIN.
- DRAIN:
  - No fetch.
  - When queue_count reaches 0 (including via the pop in this cycle), go to HALTED.
- HALTED:
  - done=1.
  - start behaves as in IDLE: load start_pc, go to RUN, done deasserts next cycle.
- Pop: inst_valid && inst_ready. Removes the head; the read pointer advances modulo DEPTH.
- Latency: fetch in cycle N appears at inst_valid in N+1. start sampled at cycle T gives first inst_valid at T+2.
- Redirect (RUN or DRAIN):
  - flush the queue (count=0, pointers reset);
  - pc <= redirect_pc; state <= RUN.
  - Redirect overrides any push and pop in the same cycle; the popped head is still considered consumed by the decoder.
  - Redirect is ignored in IDLE and HALTED.
- Simultaneous push+pop: count unchanged, both pointers advance.
- start while in RUN or DRAIN is ignored.
- redirect_pc and start_pc at or beyond INST_MEM_SIZE are reduced modulo INST_MEM_SIZE.

Decomposition:
- mat_pkg holds:
  - MatFetchState_t enum {FETCH_IDLE, FETCH_RUN, FETCH_DRAIN, FETCH_HALTED};
  - HALT opcode default constant.
- Sub-module mat_fetch_fifo:
  - parametrised DEPTH × (INST_MEM_ADDR_SIZE + INST_MEM_WIDTH_SIZE);
  - push, pop, flush, full, empty, count.
- The top level holds the FSM, PC and halt detection.

Test Plan:
1. Reset, then memory words 0..5 with word 5 = HALT, start_pc=0, inst_ready=1 -> inst_pc 0,1,2,3,4 on consecutive cycles from T+2; done=1 one cycle after pc 4 is popped; HALT never appears on inst_data.
2. inst_ready=0, DEPTH=4, start -> queue_count goes 1,2,3,4 then holds 4; inst_mem_addr holds 4. Raise inst_ready -> one pop and one push per cycle, count stays 4.
3. Queue holds pc 10..13 and redirect_valid with redirect_pc=40 -> next cycle count=0 and inst_valid=0; following cycle inst_pc=40.
4. start_pc=1022 with INST_MEM_SIZE=1024 -> inst_pc sequence 1022, 1023, 0, 1.
5. Reset asserted while queue_count=3 in RUN -> next cycle queue_count=0, inst_valid=0, done=0, state IDLE; start_pc=7 then yields first inst_pc=7.
6. In DRAIN with 2 entries, redirect_pc=100 -> returns to RUN and fetches from 100, done stays 0. In HALTED, redirect -> ignored, done stays 1.
